// File: rtl/register_1_pkg.sv
// Shared constants for the register_1 storage element family.
package register_1_pkg;

  // Default and legal data widths for register_1 instances.
  localparam int REG_WIDTH_DEFAULT = 1;
  localparam int REG_WIDTH_MIN     = 1;
  localparam int REG_WIDTH_MAX     = 1024;

endpackage : register_1_pkg

// File: rtl/register_1_dff_en_bit.sv
// Single-bit flop with load enable and an asynchronous active-high reset
// to a per-bit reset value. Building block of register_1.
module dff_en_bit #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  logic q_d;
  logic q_q;

  // Next state: take d on an enabled edge, otherwise recirculate the held bit.
  // NOTE: q_d gets its hold value first, so every path assigns it and no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  // Storage flop; reset is asynchronous and overrides the clock.
  // NOTE: non-blocking assignment keeps all flops sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  // Output comes straight from the flop: no combinational path from d/en.
  assign q = q_q;

endmodule : dff_en_bit

// File: rtl/register_1.sv
// Parameterised data register with load enable and asynchronous
// active-high reset, built from WIDTH single-bit enable flops.
module register_1
  import register_1_pkg::*;
#(
  parameter int                 WIDTH       = REG_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reject widths outside the supported range at elaboration time.
  if (WIDTH < REG_WIDTH_MIN) begin : g_width_too_small
    $error("register_1: WIDTH (%0d) must be at least %0d", WIDTH, REG_WIDTH_MIN);
  end
  if (WIDTH > REG_WIDTH_MAX) begin : g_width_too_large
    $error("register_1: WIDTH (%0d) must not exceed %0d", WIDTH, REG_WIDTH_MAX);
  end

  // One enable flop per bit, each resetting to its own bit of RESET_VALUE.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_en_bit #(
      .RESET_VALUE (RESET_VALUE[i])
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (d[i]),
      .q   (q[i])
    );
  end

endmodule : register_1

// File: tb/tb_register_1.sv
// Directed self-checking bench for register_1: a default 1-bit instance
// driven on an absolute timeline, and an 8-bit instance with reset value A5.
module tb_register_1;

  logic       clk;
  logic       rst1;
  logic       en1;
  logic [0:0] d1;
  logic [0:0] q1;

  logic       rst8;
  logic       en8;
  logic [7:0] d8;
  logic [7:0] q8;

  int errors;
  int checks;

  register_1 u_dut1 (
    .clk (clk),
    .rst (rst1),
    .en  (en1),
    .d   (d1),
    .q   (q1)
  );

  register_1 #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) u_dut8 (
    .clk (clk),
    .rst (rst8),
    .en  (en8),
    .d   (d8),
    .q   (q8)
  );

  // 40 ns period, rising edges at 20, 60, 100 ns ...
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // Absolute upper bound on run time.
  initial begin
    #50000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  // Scenarios 1-4 on the 1-bit instance, timed from t = 0.
  task automatic test_w1_timeline();
    rst1 = 1'b0; en1 = 1'b1; d1 = 1'b1;
    #21; // t = 21
    checks++;
    if (q1 !== 1'b1) begin
      errors++; $display("FAIL w1_capture_before_reset: q=%b expected=%b", q1, 1'b1);
    end
    #4;  // t = 25
    rst1 = 1'b1; en1 = 1'b0; d1 = 1'b0;
    #1;  // t = 26
    checks++;
    if (q1 !== 1'b0) begin
      errors++; $display("FAIL w1_async_reset: q=%b expected=%b", q1, 1'b0);
    end
    #14; // t = 40
    en1 = 1'b1; d1 = 1'b0;
    #10; // t = 50
    rst1 = 1'b0;
    #5;  // t = 55
    checks++;
    if (q1 !== 1'b0) begin
      errors++; $display("FAIL w1_after_release: q=%b expected=%b", q1, 1'b0);
    end
    #6;  // t = 61
    checks++;
    if (q1 !== 1'b0) begin
      errors++; $display("FAIL w1_load_zero: q=%b expected=%b", q1, 1'b0);
    end
    #4;  // t = 65
    en1 = 1'b0; d1 = 1'b1;
    #20; // t = 85
    checks++;
    if (q1 !== 1'b0) begin
      errors++; $display("FAIL w1_d_without_edge: q=%b expected=%b", q1, 1'b0);
    end
    #5;  // t = 90
    en1 = 1'b1; d1 = 1'b1;
    #5;  // t = 95
    checks++;
    if (q1 !== 1'b0) begin
      errors++; $display("FAIL w1_before_load_edge: q=%b expected=%b", q1, 1'b0);
    end
    #6;  // t = 101
    checks++;
    if (q1 !== 1'b1) begin
      errors++; $display("FAIL w1_load_one: q=%b expected=%b", q1, 1'b1);
    end
  endtask

  // 1-bit hold with en = 0 across several edges while d toggles.
  task automatic test_w1_hold();
    @(negedge clk);
    en1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d1 = i[0];
      @(posedge clk); #1;
      checks++;
      if (q1 !== 1'b1) begin
        errors++; $display("FAIL w1_hold_edge%0d: q=%b expected=%b", i, q1, 1'b1);
      end
      @(negedge clk);
    end
  endtask

  // Scenario 5: reset value, load, hold, reset coincident with an edge.
  task automatic test_w8_basic();
    @(negedge clk);
    rst8 = 1'b1; en8 = 1'b0; d8 = 8'h00;
    #1;
    checks++;
    if (q8 !== 8'hA5) begin
      errors++; $display("FAIL w8_reset_value: q=%h expected=%h", q8, 8'hA5);
    end
    @(negedge clk);
    rst8 = 1'b0; en8 = 1'b1; d8 = 8'h3C;
    @(posedge clk); #1;
    checks++;
    if (q8 !== 8'h3C) begin
      errors++; $display("FAIL w8_load_3c: q=%h expected=%h", q8, 8'h3C);
    end
    @(negedge clk);
    en8 = 1'b0; d8 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (q8 !== 8'h3C) begin
        errors++; $display("FAIL w8_hold_edge%0d: q=%h expected=%h", i, q8, 8'h3C);
      end
    end
    @(negedge clk);
    en8 = 1'b1; d8 = 8'h00;
    @(posedge clk);
    rst8 = 1'b1;
    #1;
    checks++;
    if (q8 !== 8'hA5) begin
      errors++; $display("FAIL w8_reset_at_edge: q=%h expected=%h", q8, 8'hA5);
    end
  endtask

  // Scenario 6: reset held over 4 edges, then first enabled edge captures.
  task automatic test_w8_reset_held();
    logic [7:0] pattern [4];
    pattern[0] = 8'h5A; pattern[1] = 8'hFF; pattern[2] = 8'h00; pattern[3] = 8'h12;
    @(negedge clk);
    rst8 = 1'b1; en8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d8 = pattern[i];
      @(posedge clk); #1;
      checks++;
      if (q8 !== 8'hA5) begin
        errors++; $display("FAIL w8_reset_held_edge%0d: q=%h expected=%h", i, q8, 8'hA5);
      end
      @(negedge clk);
    end
    rst8 = 1'b0; d8 = 8'hC3;
    #5;
    checks++;
    if (q8 !== 8'hA5) begin
      errors++; $display("FAIL w8_release_no_edge: q=%h expected=%h", q8, 8'hA5);
    end
    @(posedge clk); #1;
    checks++;
    if (q8 !== 8'hC3) begin
      errors++; $display("FAIL w8_first_capture: q=%h expected=%h", q8, 8'hC3);
    end
  endtask

  // Consecutive enabled loads: each edge replaces the previous value.
  task automatic test_back_to_back();
    logic [7:0] vec [4];
    vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h80; vec[3] = 8'h01;
    en8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d8 = vec[i];
      @(posedge clk); #1;
      checks++;
      if (q8 !== vec[i]) begin
        errors++; $display("FAIL b2b_load%0d: q=%h expected=%h", i, q8, vec[i]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst8 = 1'b0; en8 = 1'b0; d8 = 8'h00;
    test_w1_timeline();
    test_w1_hold();
    test_w8_basic();
    test_w8_reset_held();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_register_1

// File: doc/register_1.md
# register_1

Parameterised edge-triggered data register with a load enable and an asynchronous active-high reset. It is the basic storage element for holding configuration words, pipeline data or status bits wherever a value must be captured only on qualified clock edges and held otherwise. The default configuration is a single-bit flop with enable, `WIDTH = 1`.

## Interface
- `WIDTH`, default 1: data width in bits; legal range 1 to 1024.
- `RESET_VALUE`, default 0: value `q` takes during reset, `WIDTH` bits.
- `clk`, input, 1 bit: clock; all captures happen on the rising edge.
- `rst`, input, 1 bit: reset.
  - One clock; reset is asynchronous and active-high.
  - `q` goes to `RESET_VALUE` immediately when `rst` rises and stays there while `rst` = 1.
- `en`, input, 1 bit: load enable, sampled on the rising edge of `clk`.
- `d`, input, `WIDTH` bits: data to capture.
- `q`, output, `WIDTH` bits: registered value, driven directly from flops.

## Operation
- Reset has priority over everything.
  - While `rst` = 1, `q` = `RESET_VALUE` regardless of `clk`, `en` and `d`.
- With `rst` = 0, on each rising edge of `clk`:
  - `en` = 1: `q` takes the value of `d` as sampled at that edge.
  - `en` = 0: `q` holds its value; all bits are preserved.
- Changes to `d` or `en` between clock edges have no effect on `q`.
- No combinational path exists from `d`, `en` or `clk` to `q`. The only asynchronous path to `q` is the reset.
- Power-up: `q` is undefined until the first reset assertion or the first enabled capture. The system must apply reset before `q` is consumed.
- Reset applied mid-operation discards the held value unconditionally. After release, a capture needs an enabled edge.

## Timing
- Load latency is 1 cycle: `d` presented with `en` = 1 before edge N appears on `q` just after edge N.
- Hold with `en` = 0 is indefinite.
- Reset assertion takes effect within the same simulation timestep as the `rst` rising transition, with no clock required.
- Reset release: the first edge that can update `q` is the first rising edge of `clk` at which `rst` = 0.
  - Release must meet recovery/removal timing relative to `clk`; synchronising `rst` is the system's responsibility.
- Reset and a clock edge in the same timestep: reset wins, and `q` = `RESET_VALUE`.
- Setup and hold timing applies to `d` and `en` relative to the rising edge of `clk`.

## Structure
- No shared package is required.
  - If the codebase keeps a common package, put a `reg_width_t`-style default width constant there. `RESET_VALUE` stays a module parameter.
- One natural sub-module, `dff_en_bit`: a single-bit flop with async active-high reset, enable and a per-bit reset value.
- The top level instantiates `WIDTH` copies of `dff_en_bit` in a generate loop, passing each the corresponding bit of `RESET_VALUE`.
- Include parameter-legality checks: elaboration error if `WIDTH` < 1.

## Test plan
Clock period is 40 ns, with rising edges at 20, 60 and 100 ns. Scenarios 1–4 run with `WIDTH` = 1 and `RESET_VALUE` = 0.

1. Capture before any reset: `en` = 1, `d` = 1 from t = 0 → `q` = 1 after the edge at 20 ns.
2. Async reset mid-cycle: `rst` = 1 from 25 to 50 ns with `en` = 0 and `d` = 0 → `q` = 0 at 25 ns, before any clock edge.
3. Enabled load of 0: `en` = 1, `d` = 0 from 40 ns → `q` stays 0 after the edge at 60 ns.
4. Hold, then load:
   - `en` = 0, `d` = 1 from 65 ns → `q` = 0 is held; `d` alone does not change `q`.
   - `en` = 1, `d` = 1 from 90 ns → `q` = 1 after the edge at 100 ns.
5. `WIDTH` = 8, `RESET_VALUE` = 8'hA5:
   - Reset → `q` = A5.
   - Load 8'h3C with `en` = 1 → `q` = 3C next edge.
   - Then `en` = 0 with `d` = FF for 3 edges → `q` stays 3C.
   - Assert `rst` coincident with a clock edge while `en` = 1 and `d` = 00 → `q` = A5.
6. Reset held across edges: `rst` = 1 with `en` = 1 and `d` toggling for 4 edges → `q` = `RESET_VALUE` throughout. After release, the first enabled edge captures `d`.
